// File: rtl/liteic_slave_node_write_arbiter_if.sv
// Write-path bundle between the master write nodes, the slave-slot write arbiter and the slave.
// Latency: none, this is wiring only.
// Backpressure: carries per-master valid/ready and the slave-side AXI-Lite AW/W/B handshakes.
// Modport slave is the arbiter's view. Modport master is the surrounding fabric (master nodes plus slave).
interface liteic_slave_node_write_arbiter_if #(
  parameter int NUM_MASTERS  = 4,
  parameter int AWADDR_WIDTH = 32,
  parameter int WDATA_WIDTH  = 36,
  parameter int BRESP_WIDTH  = 2
);
  logic [NUM_MASTERS-1:0]              mst_aw_val_i;
  logic [NUM_MASTERS-1:0]              mst_aw_rdy_o;
  logic [NUM_MASTERS*AWADDR_WIDTH-1:0] mst_aw_data_i;
  logic [NUM_MASTERS-1:0]              mst_w_val_i;
  logic [NUM_MASTERS-1:0]              mst_w_rdy_o;
  logic [NUM_MASTERS*WDATA_WIDTH-1:0]  mst_w_data_i;
  logic [NUM_MASTERS-1:0]              mst_b_val_o;
  logic [NUM_MASTERS-1:0]              mst_b_rdy_i;
  logic [BRESP_WIDTH-1:0]              mst_b_resp_o;
  logic                                slv_aw_val_o;
  logic                                slv_aw_rdy_i;
  logic [AWADDR_WIDTH-1:0]             slv_aw_data_o;
  logic                                slv_w_val_o;
  logic                                slv_w_rdy_i;
  logic [WDATA_WIDTH-1:0]              slv_w_data_o;
  logic                                slv_b_val_i;
  logic                                slv_b_rdy_o;
  logic [BRESP_WIDTH-1:0]              slv_b_resp_i;

  modport slave (
    input  mst_aw_val_i, mst_aw_data_i, mst_w_val_i, mst_w_data_i, mst_b_rdy_i,
    input  slv_aw_rdy_i, slv_w_rdy_i, slv_b_val_i, slv_b_resp_i,
    output mst_aw_rdy_o, mst_w_rdy_o, mst_b_val_o, mst_b_resp_o,
    output slv_aw_val_o, slv_aw_data_o, slv_w_val_o, slv_w_data_o, slv_b_rdy_o
  );

  modport master (
    output mst_aw_val_i, mst_aw_data_i, mst_w_val_i, mst_w_data_i, mst_b_rdy_i,
    output slv_aw_rdy_i, slv_w_rdy_i, slv_b_val_i, slv_b_resp_i,
    input  mst_aw_rdy_o, mst_w_rdy_o, mst_b_val_o, mst_b_resp_o,
    input  slv_aw_val_o, slv_aw_data_o, slv_w_val_o, slv_w_data_o, slv_b_rdy_o
  );
endinterface

// File: rtl/liteic_slave_node_write_arbiter.sv
// Round-robin arbiter sharing one slave's AXI-Lite AW/W/B channels among NUM_MASTERS write nodes.
// Latency: AW valid seen in IDLE reaches the slave two cycles later; AW/W/B payload paths are combinational.
// Backpressure: slave and master readies pass straight through to the granted master only. One transaction in flight.
// Ports: clk_i/rstn_i (async active-low), bus (write channels, slave modport),
//        grant_o (granted master index), busy_o (any state other than IDLE).
module liteic_slave_node_write_arbiter #(
  parameter int NUM_MASTERS  = 4,
  parameter int AWADDR_WIDTH = 32,
  parameter int WDATA_WIDTH  = 36,
  parameter int BRESP_WIDTH  = 2,
  parameter int GRANT_WIDTH  = $clog2(NUM_MASTERS)
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  liteic_slave_node_write_arbiter_if.slave    bus,
  output logic [GRANT_WIDTH-1:0]              grant_o,
  output logic                                busy_o
);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, RESP} state_t;

  state_t                 state_q, state_d;
  logic [GRANT_WIDTH-1:0] g_q, g_d;
  logic [GRANT_WIDTH-1:0] rr_q, rr_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic [GRANT_WIDTH-1:0] pick;

  logic                   aw_hs, w_hs;
  logic [NUM_MASTERS-1:0] aw_rdy, w_rdy, b_val;
  logic                   aw_val, w_val, b_rdy;
  logic [AWADDR_WIDTH-1:0] aw_data;
  logic [WDATA_WIDTH-1:0]  w_data;
  logic [BRESP_WIDTH-1:0]  b_resp;

  // First requesting master scanning upward from rr_q, wrapping at NUM_MASTERS.
  always_comb begin
    pick = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (bus.mst_aw_val_i[(int'(rr_q) + i) % NUM_MASTERS])
        pick = GRANT_WIDTH'((int'(rr_q) + i) % NUM_MASTERS);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      g_q       <= '0;
      rr_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      rr_q      <= rr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    rr_d      = rr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_rdy    = '0;
    w_rdy     = '0;
    b_val     = '0;
    aw_val    = 1'b0;
    w_val     = 1'b0;
    b_rdy     = 1'b0;
    aw_data   = '0;
    w_data    = '0;
    b_resp    = '0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;

    case (state_q)
      IDLE: begin
        // Only AW valid opens arbitration; a lone W valid waits.
        if (|bus.mst_aw_val_i) begin
          g_d     = pick;
          state_d = GRANT;
        end
      end
      GRANT: state_d = XFER;
      XFER: begin
        // Done flags mask the channel so a second beat from the master is never accepted.
        aw_val     = bus.mst_aw_val_i[g_q] & ~aw_done_q;
        aw_rdy[g_q] = bus.slv_aw_rdy_i & ~aw_done_q;
        w_val      = bus.mst_w_val_i[g_q] & ~w_done_q;
        w_rdy[g_q] = bus.slv_w_rdy_i & ~w_done_q;
        aw_data    = bus.mst_aw_data_i[g_q*AWADDR_WIDTH +: AWADDR_WIDTH];
        w_data     = bus.mst_w_data_i[g_q*WDATA_WIDTH +: WDATA_WIDTH];
        aw_hs      = aw_val & bus.slv_aw_rdy_i;
        w_hs       = w_val & bus.slv_w_rdy_i;
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d   = RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      RESP: begin
        b_val[g_q] = bus.slv_b_val_i;
        b_rdy      = bus.mst_b_rdy_i[g_q];
        b_resp     = bus.slv_b_resp_i;
        if (bus.slv_b_val_i && bus.mst_b_rdy_i[g_q]) begin
          rr_d    = (g_q == GRANT_WIDTH'(NUM_MASTERS - 1)) ? '0 : g_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mst_aw_rdy_o  = aw_rdy;
  assign bus.mst_w_rdy_o   = w_rdy;
  assign bus.mst_b_val_o   = b_val;
  assign bus.mst_b_resp_o  = b_resp;
  assign bus.slv_aw_val_o  = aw_val;
  assign bus.slv_aw_data_o = aw_data;
  assign bus.slv_w_val_o   = w_val;
  assign bus.slv_w_data_o  = w_data;
  assign bus.slv_b_rdy_o   = b_rdy;

  assign grant_o = (state_q == IDLE) ? '0 : g_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_liteic_slave_node_write_arbiter.sv
module tb_liteic_slave_node_write_arbiter;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int WW = 36;
  localparam int BW = 2;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic [1:0] grant_o;
  logic       busy_o;
  int         errors = 0;
  int         checks = 0;

  liteic_slave_node_write_arbiter_if #(.NUM_MASTERS(NM), .AWADDR_WIDTH(AW), .WDATA_WIDTH(WW), .BRESP_WIDTH(BW)) bif ();

  liteic_slave_node_write_arbiter #(.NUM_MASTERS(NM), .AWADDR_WIDTH(AW), .WDATA_WIDTH(WW), .BRESP_WIDTH(BW)) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .bus     (bif.slave),
    .grant_o (grant_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clear_inputs();
    bif.mst_aw_val_i  = '0;
    bif.mst_aw_data_i = '0;
    bif.mst_w_val_i   = '0;
    bif.mst_w_data_i  = '0;
    bif.mst_b_rdy_i   = '1;
    bif.slv_aw_rdy_i  = 1'b1;
    bif.slv_w_rdy_i   = 1'b1;
    bif.slv_b_val_i   = 1'b0;
    bif.slv_b_resp_i  = '0;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    clear_inputs();
    cyc();
    cyc();
    rstn_i = 1'b1;
    cyc();
  endtask

  // Called in RESP: slave offers B, granted master accepts, back to IDLE.
  task automatic finish_b(input string tag, input logic [3:0] mask, input logic [1:0] resp);
    bif.slv_b_val_i  = 1'b1;
    bif.slv_b_resp_i = resp;
    bif.mst_b_rdy_i  = '1;
    #1;
    chk({tag, "_bval"}, bif.mst_b_val_o, mask);
    chk({tag, "_bresp"}, bif.mst_b_resp_o, resp);
    chk({tag, "_brdy"}, bif.slv_b_rdy_o, 1);
    cyc();
    #1;
    chk({tag, "_idle"}, busy_o, 0);
    bif.slv_b_val_i = 1'b0;
  endtask

  logic [31:0] aw_pay [NM];
  int          n;
  logic [1:0]  exp_g;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    #1;
    // Reset state, with a stray slave B valid that must not be acknowledged.
    bif.slv_b_val_i = 1'b1;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_brdy", bif.slv_b_rdy_o, 0);
    chk("rst_awval", bif.slv_aw_val_o, 0);
    do_reset();

    // Single master 2.
    bif.mst_aw_val_i = 4'b0100;
    bif.mst_w_val_i  = 4'b0100;
    bif.mst_aw_data_i[2*AW +: AW] = 32'h1000_0040;
    bif.mst_w_data_i[2*WW +: WW]  = 36'h0_DEAD_BEEF;
    #1;
    chk("t1_idle_awval", bif.slv_aw_val_o, 0);
    cyc(); #1;
    chk("t1_grant_awval", bif.slv_aw_val_o, 0);
    chk("t1_grant_busy", busy_o, 1);
    chk("t1_grant_idx", grant_o, 2);
    cyc(); #1;
    chk("t1_xfer_awval", bif.slv_aw_val_o, 1);
    chk("t1_xfer_awdata", bif.slv_aw_data_o, 32'h1000_0040);
    chk("t1_xfer_wdata", bif.slv_w_data_o, 36'h0_DEAD_BEEF);
    chk("t1_xfer_awrdy", bif.mst_aw_rdy_o, 4'b0100);
    chk("t1_xfer_wrdy", bif.mst_w_rdy_o, 4'b0100);
    cyc();
    bif.mst_aw_val_i = '0;
    bif.mst_w_val_i  = '0;
    #1;
    chk("t1_resp_awval", bif.slv_aw_val_o, 0);
    finish_b("t1", 4'b0100, 2'b00);
    bif.slv_b_val_i = 1'b1;
    #1;
    chk("t1_idle_brdy", bif.slv_b_rdy_o, 0);
    bif.slv_b_val_i = 1'b0;

    // W before AW from master 1: W alone must not start arbitration.
    cyc();
    bif.mst_w_val_i = 4'b0010;
    bif.mst_w_data_i[1*WW +: WW] = 36'h1_1111_2222;
    bif.mst_aw_data_i[1*AW +: AW] = 32'h2000_0010;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("t2_w_only_busy", busy_o, 0);
    end
    bif.mst_aw_val_i = 4'b0010;
    cyc(); #1;
    chk("t2_grant_idx", grant_o, 1);
    cyc(); #1;
    chk("t2_xfer_awval", bif.slv_aw_val_o, 1);
    chk("t2_xfer_wval", bif.slv_w_val_o, 1);
    chk("t2_xfer_wdata", bif.slv_w_data_o, 36'h1_1111_2222);
    cyc();
    #1;
    chk("t2_resp_wval", bif.slv_w_val_o, 0);
    chk("t2_resp_wrdy", bif.mst_w_rdy_o, 0);
    bif.mst_aw_val_i = '0;
    bif.mst_w_val_i  = '0;
    finish_b("t2", 4'b0010, 2'b00);

    // Masters 0 and 3 contend with rr_ptr = 2: master 3 first, then master 0.
    cyc();
    bif.mst_aw_val_i = 4'b1001;
    bif.mst_w_val_i  = 4'b1001;
    bif.mst_aw_data_i[0*AW +: AW] = 32'h3000_0000;
    bif.mst_aw_data_i[3*AW +: AW] = 32'h3000_0033;
    cyc(); #1;
    chk("t5_first_grant", grant_o, 3);
    cyc(); #1;
    chk("t5_awrdy", bif.mst_aw_rdy_o, 4'b1000);
    chk("t5_wrdy", bif.mst_w_rdy_o, 4'b1000);
    chk("t5_awdata", bif.slv_aw_data_o, 32'h3000_0033);
    cyc();
    bif.mst_aw_val_i = 4'b0001;
    bif.mst_w_val_i  = 4'b0001;
    #1;
    chk("t5_resp_direct", bif.slv_aw_val_o, 0);
    chk("t5_resp_busy", busy_o, 1);
    finish_b("t5a", 4'b1000, 2'b10);
    cyc(); #1;
    chk("t5_second_grant", grant_o, 0);
    cyc(); #1;
    chk("t5b_awdata", bif.slv_aw_data_o, 32'h3000_0000);
    cyc();
    bif.mst_aw_val_i = '0;
    bif.mst_w_val_i  = '0;
    finish_b("t5b", 4'b0001, 2'b01);

    // Slave AW backpressure for 5 cycles, then master 0 holds off B for 4 cycles.
    cyc();
    bif.slv_aw_rdy_i = 1'b0;
    bif.mst_aw_val_i = 4'b0001;
    bif.mst_w_val_i  = 4'b0001;
    bif.mst_aw_data_i[0*AW +: AW] = 32'hB000_0004;
    cyc();
    cyc(); #1;
    chk("t4_w_first", bif.slv_w_val_o, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("t4_aw_hold", bif.slv_aw_val_o, 1);
      chk("t4_aw_stable", bif.slv_aw_data_o, 32'hB000_0004);
      chk("t4_no_second_w", bif.slv_w_val_o, 0);
      chk("t4_no_second_wrdy", bif.mst_w_rdy_o, 0);
    end
    bif.slv_aw_rdy_i = 1'b1;
    cyc();
    bif.mst_aw_val_i = '0;
    bif.mst_w_val_i  = '0;
    bif.slv_b_val_i  = 1'b1;
    bif.mst_b_rdy_i  = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_brdy_low", bif.slv_b_rdy_o, 0);
      chk("t4_bval", bif.mst_b_val_o, 4'b0001);
      chk("t4_busy", busy_o, 1);
      cyc();
    end
    finish_b("t4", 4'b0001, 2'b00);

    // Asynchronous reset after the AW handshake only.
    cyc();
    bif.slv_w_rdy_i  = 1'b0;
    bif.mst_aw_val_i = 4'b0100;
    bif.mst_w_val_i  = 4'b0100;
    cyc();
    cyc();
    cyc();
    bif.mst_aw_val_i = '0;
    #1;
    chk("t6_pre_wval", bif.slv_w_val_o, 1);
    chk("t6_pre_awval", bif.slv_aw_val_o, 0);
    rstn_i = 1'b0;
    #1;
    chk("t6_rst_wval", bif.slv_w_val_o, 0);
    chk("t6_rst_wrdy", bif.mst_w_rdy_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_grant", grant_o, 0);
    cyc();
    clear_inputs();
    rstn_i = 1'b1;
    cyc(); #1;
    chk("t6_post_busy", busy_o, 0);
    bif.mst_aw_val_i = 4'b1001;
    bif.mst_w_val_i  = 4'b1001;
    cyc(); #1;
    chk("t6_rr_from_zero", grant_o, 0);
    cyc(); #1;
    chk("t6_fresh_aw", bif.slv_aw_val_o, 1);
    bif.mst_aw_val_i = '0;
    bif.mst_w_val_i  = '0;

    // Round-robin from reset with all four masters requesting continuously.
    do_reset();
    for (int m = 0; m < NM; m++) begin
      aw_pay[m] = 32'hA000_0000 + m;
      bif.mst_aw_data_i[m*AW +: AW] = aw_pay[m];
    end
    bif.mst_aw_val_i = '1;
    bif.mst_w_val_i  = '1;
    bif.slv_b_val_i  = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 8; c++) begin
      cyc(); #1;
      if (bif.slv_aw_val_o && bif.slv_aw_rdy_i) begin
        exp_g = 2'(n % NM);
        chk("rr_grant", grant_o, exp_g);
        chk("rr_awdata", bif.slv_aw_data_o, aw_pay[exp_g]);
        n++;
      end
    end
    chk("rr_count", n, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
